fetch_predecode_bp: RTL
=======================

# fetch_predecode_bp

Fetch-stage pre-decoder and branch predictor for the RV32 core. Decodes the fetched instruction word, computes the JAL, JALR and branch targets, and predicts direction and target in the fetch cycle. Conditional branches use a bimodal table of 2-bit counters trained by execute. Returns use an optional return-address stack (RAS).

## Interface
Parameters:
- BHT_IDX_W, 6, log2 of BHT entries; indexed by pc[BHT_IDX_W+1:2]
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)
- JALR_DEP_DEPTH, 1, stages checked for JALR rs1 hazard: 1 = dec, 2 = dec+exe, 3 = dec+exe+mem

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  core clock
  - rst  in  1  synchronous active-high reset
- Fetch inputs:
  - fet_valid  in  1  fet_instr/fet_pc valid
  - fet_accept  in  1  fetch advances this cycle; commits RAS push/pop
  - fet_pc  in  32  PC of fetched instruction
  - fet_instr  in  32  fetched instruction word
- Register values for JALR:
  - r_x1  in  32  fast-path x1 value
  - rs1v  in  32  regfile value of fetch_rs1n
- Hazard inputs:
  - dec_rd, exe_rd, mem_rd  in  5 each  destination register per stage
  - dec_wen, exe_wen, mem_wen  in  1 each  regfile write enable per stage
- Branch resolution from execute:
  - ex_br_valid  in  1  a conditional branch resolved this cycle
  - ex_br_pc  in  32  PC of the resolved branch
  - ex_br_taken  in  1  actual direction
- Decode outputs:
  - isjal, isjalr, isbxx, ismret  out  1 each  opcode decode; ismret = word equals 0x30200073
  - fetch_rs1n  out  5  fet_instr[19:15]
  - if_csr_r_index  out  12  fet_instr[31:20]
- Prediction outputs:
  - predict_taken  out  1  redirect fetch this cycle
  - pred_target  out  32  redirect target
  - ras_hit  out  1  JALR target taken from the RAS
  - jalr_dep  out  1  stall fetch; JALR rs1 is not yet written back

## Operation
- Decode is combinational and gated by fet_valid. When fet_valid=0, every decode and prediction output is 0.
- Immediates are sign-extended to 32 bits:
  - JAL offset = J-imm with bit0 = 0.
  - Branch offset = B-imm with bit0 = 0.
  - JALR offset = I-imm.
- Target computation:
  - JAL: predict_taken=1, pred_target = fet_pc + jal offset.
  - Branch: predict_taken = bht[idx][1], pred_target = fet_pc + branch offset.
  - JALR, no RAS hit: pred_target = (jalr_src + imm) & ~1, where jalr_src = r_x1 if rs1=x1, rs1v if rs1∉{x0,x1}, 0 if rs1=x0. predict_taken = ~jalr_dep.
  - JALR, RAS hit: pred_target = top of RAS, predict_taken=1, jalr_dep=0.
- jalr_dep = isjalr & rs1≠x0 & (some stage s within JALR_DEP_DEPTH has s_wen & s_rd==rs1).
- BHT:
  - 2^BHT_IDX_W saturating 2-bit counters; all reset to 2'b01 (weakly not-taken).
  - On ex_br_valid, the counter at ex_br_pc[BHT_IDX_W+1:2] increments if taken and decrements if not, saturating at 0 and 3.
  - No bypass: a same-cycle read of the entry being written returns the old value.
- RAS (compiled in by FETCH_RAS_EN):
  - Link register set L = {x1, x5}.
  - Push condition: jal/jalr with rd∈L. Pushes fet_pc+4.
  - Pop condition: jalr with rs1∈L and rd∉L.
  - jalr with rd∈L and rs1∈L: pop then push (top replaced), pointer unchanged.
  - ras_hit = pop condition & count≠0.
  - Push/pop commit only when fet_valid & fet_accept & ~jalr_dep.
  - Storage is circular with pointer ptr and count 0..RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty: no hit, ptr/count unchanged, register path used.
  - Reset: ptr=0, count=0; entry contents are don't-care.
  - No repair on misprediction flush.

## Timing
- All outputs are combinational from inputs plus registered BHT/RAS state; zero latency within the fetch cycle.
- State updates on the rising clk edge after the enabling condition.
- A branch resolved in cycle N affects predictions from cycle N+1.
- RAS push in cycle N is visible to a return fetched in cycle N+1.
- rst asserted mid-operation: BHT returns to 01 and the RAS empties at that edge. While rst=1, outputs follow combinational decode of the current inputs, with state at reset values.
- Outputs at reset (fet_valid=0): all 0.

## Configuration
- FETCH_RAS_EN defined:
  - RAS storage and ras_hit are implemented.
  - A JALR return is predicted without a register hazard when the RAS is non-empty.
- FETCH_RAS_EN undefined:
  - No RAS flops; ras_hit is tied 0.
  - Every JALR uses the register path and jalr_dep.

## Test plan
- Reset, then branch at pc=0x100 with offset -8 → predict_taken=0 (counter 01). Resolve taken twice → predict_taken=1, pred_target=0xF8. Resolve not-taken 3 times → counter saturates at 0 and stays 0 on a 4th.
- JAL at 0x200 with imm 0x800 and rd=x1, accepted → predict_taken=1, pred_target=0xA00. Then `jalr x0,0(x1)` next cycle → ras_hit=1, pred_target=0x204, jalr_dep=0, even with dec_rd=1 & dec_wen=1.
- RAS_DEPTH=4: push 5 calls (return addresses A1..A5), then 5 returns → hits give A5, A4, A3, A2; the 5th return gives ras_hit=0 and falls back to the register path.
- FETCH_RAS_EN undefined, JALR_DEP_DEPTH=2: `jalr x0,4(x7)` with rs1v=0x1001 and exe_rd=7 & exe_wen=1 → jalr_dep=1, predict_taken=0. With exe_wen=0 → pred_target=0x1004.
- ex_br_valid and a fetch of the same branch pc in the same cycle → prediction uses the old counter; the next cycle uses the updated counter.
- Fetch 0x30200073 → ismret=1. rst asserted mid-sequence with RAS count 3 → next return gives ras_hit=0.

Source files
------------

// File: rtl/fetch_predecode_bp_if.sv
// Fetch-side bus of fetch_predecode_bp: fetch word, JALR operands, hazard info,
// branch resolution from execute, and the decode/prediction results.
interface fetch_predecode_bp_if;
    logic        fet_valid;
    logic        fet_accept;
    logic [31:0] fet_pc;
    logic [31:0] fet_instr;
    logic [31:0] r_x1;
    logic [31:0] rs1v;
    logic [4:0]  dec_rd;
    logic [4:0]  exe_rd;
    logic [4:0]  mem_rd;
    logic        dec_wen;
    logic        exe_wen;
    logic        mem_wen;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;

    logic        isjal;
    logic        isjalr;
    logic        isbxx;
    logic        ismret;
    logic [4:0]  fetch_rs1n;
    logic [11:0] if_csr_r_index;
    logic        predict_taken;
    logic [31:0] pred_target;
    logic        ras_hit;
    logic        jalr_dep;

    modport master (
        output fet_valid, fet_accept, fet_pc, fet_instr, r_x1, rs1v,
               dec_rd, exe_rd, mem_rd, dec_wen, exe_wen, mem_wen,
               ex_br_valid, ex_br_pc, ex_br_taken,
        input  isjal, isjalr, isbxx, ismret, fetch_rs1n, if_csr_r_index,
               predict_taken, pred_target, ras_hit, jalr_dep
    );

    modport slave (
        input  fet_valid, fet_accept, fet_pc, fet_instr, r_x1, rs1v,
               dec_rd, exe_rd, mem_rd, dec_wen, exe_wen, mem_wen,
               ex_br_valid, ex_br_pc, ex_br_taken,
        output isjal, isjalr, isbxx, ismret, fetch_rs1n, if_csr_r_index,
               predict_taken, pred_target, ras_hit, jalr_dep
    );
endinterface

// File: rtl/fetch_predecode_bp.sv
// Fetch-stage pre-decoder with bimodal branch predictor and JALR target prediction.
// Define FETCH_RAS_EN to build in the return-address stack.
module fetch_predecode_bp #(
    parameter int unsigned BHT_IDX_W      = 6,
    parameter int unsigned RAS_DEPTH      = 4,
    parameter int unsigned JALR_DEP_DEPTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    fetch_predecode_bp_if.slave bus
);

    localparam int unsigned BHT_N    = 1 << BHT_IDX_W;
    localparam logic [6:0]  OPC_JAL  = 7'b1101111;
    localparam logic [6:0]  OPC_JALR = 7'b1100111;
    localparam logic [6:0]  OPC_BR   = 7'b1100011;
    localparam logic [31:0] MRET_W   = 32'h3020_0073;

    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic        is_jal;
    logic        is_jalr;
    logic        is_br;
    logic        is_mret;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] imm_i;

    assign instr = bus.fet_instr;
    assign pc    = bus.fet_pc;
    assign opc   = instr[6:0];
    assign rs1   = instr[19:15];

    assign is_jal  = bus.fet_valid && (opc == OPC_JAL);
    assign is_jalr = bus.fet_valid && (opc == OPC_JALR);
    assign is_br   = bus.fet_valid && (opc == OPC_BR);
    assign is_mret = bus.fet_valid && (instr == MRET_W);

    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_i = {{20{instr[31]}}, instr[31:20]};

    // Register hazard on rs1 across the configured number of pipeline stages.
    logic hazard;
    always_comb begin
        hazard = 1'b0;
        if (JALR_DEP_DEPTH >= 1 && bus.dec_wen && bus.dec_rd == rs1) hazard = 1'b1;
        if (JALR_DEP_DEPTH >= 2 && bus.exe_wen && bus.exe_rd == rs1) hazard = 1'b1;
        if (JALR_DEP_DEPTH >= 3 && bus.mem_wen && bus.mem_rd == rs1) hazard = 1'b1;
    end

    logic [31:0] jalr_src;
    logic [31:0] jalr_sum;
    logic [31:0] jalr_tgt;
    always_comb begin
        if (rs1 == 5'd0)
            jalr_src = '0;
        else if (rs1 == 5'd1)
            jalr_src = bus.r_x1;
        else
            jalr_src = bus.rs1v;
    end
    assign jalr_sum = jalr_src + imm_i;
    assign jalr_tgt = {jalr_sum[31:1], 1'b0};

    logic        ras_hit_w;
    logic [31:0] ras_top;
    logic        jalr_dep_w;

    assign jalr_dep_w = is_jalr && (rs1 != 5'd0) && hazard && !ras_hit_w;

    // Bimodal table; the read path sees only registered counters, never the
    // update being written in the same cycle.
    logic [1:0]           bht_q [BHT_N];
    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] wr_idx;
    logic [1:0]           wr_ctr;
    logic [1:0]           wr_ctr_d;

    assign rd_idx = pc[BHT_IDX_W+1:2];
    assign wr_idx = bus.ex_br_pc[BHT_IDX_W+1:2];
    assign wr_ctr = bht_q[wr_idx];

    always_comb begin
        wr_ctr_d = wr_ctr;
        if (bus.ex_br_taken) begin
            if (wr_ctr != 2'b11) wr_ctr_d = wr_ctr + 2'd1;
        end else begin
            if (wr_ctr != 2'b00) wr_ctr_d = wr_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (bus.ex_br_valid) begin
            bht_q[wr_idx] <= wr_ctr_d;
        end
    end

`ifdef FETCH_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [PTR_W-1:0] top_ptr;
    logic [4:0]       rd;
    logic             rd_link;
    logic             rs1_link;
    logic             ras_nonempty;
    logic             commit;
    logic             do_push;
    logic             do_pop;
    logic [31:0]      link_addr;

    assign rd           = instr[11:7];
    assign rd_link      = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link     = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign ras_nonempty = (cnt_q != '0);
    assign top_ptr      = ptr_q - PTR_W'(1);
    assign ras_top      = ras_q[top_ptr];
    assign link_addr    = pc + 32'd4;

    // Only a pure return (rd not a link register) is predicted from the stack;
    // a jalr with both rd and rs1 in the link set still swaps the top entry.
    assign ras_hit_w = is_jalr && rs1_link && !rd_link && ras_nonempty;

    assign commit  = bus.fet_valid && bus.fet_accept && !jalr_dep_w;
    assign do_push = commit && (is_jal || is_jalr) && rd_link;
    assign do_pop  = commit && is_jalr && rs1_link && ras_nonempty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; a full push overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push && do_pop)
                ras_q[top_ptr] <= link_addr;
            else if (do_push)
                ras_q[ptr_q] <= link_addr;
        end
    end
`else
    logic unused_accept;

    assign ras_hit_w     = 1'b0;
    assign ras_top       = '0;
    assign unused_accept = bus.fet_accept;
`endif

    logic unused_brpc;
    assign unused_brpc = ^{bus.ex_br_pc[31:BHT_IDX_W+2], bus.ex_br_pc[1:0]};

    logic        taken;
    logic [31:0] target;
    always_comb begin
        taken  = 1'b0;
        target = '0;
        if (is_jal) begin
            taken  = 1'b1;
            target = pc + imm_j;
        end else if (is_br) begin
            taken  = bht_q[rd_idx][1];
            target = pc + imm_b;
        end else if (is_jalr) begin
            if (ras_hit_w) begin
                taken  = 1'b1;
                target = ras_top;
            end else begin
                taken  = !jalr_dep_w;
                target = jalr_tgt;
            end
        end
    end

    assign bus.isjal          = is_jal;
    assign bus.isjalr         = is_jalr;
    assign bus.isbxx          = is_br;
    assign bus.ismret         = is_mret;
    assign bus.fetch_rs1n     = bus.fet_valid ? rs1 : 5'd0;
    assign bus.if_csr_r_index = bus.fet_valid ? instr[31:20] : 12'd0;
    assign bus.predict_taken  = taken;
    assign bus.pred_target    = target;
    assign bus.ras_hit        = ras_hit_w;
    assign bus.jalr_dep       = jalr_dep_w;

endmodule
